tag_reorder_buffer: RTL and testbench
=====================================

Name: tag_reorder_buffer

Overview:
Parametrised tag-addressed holding buffer for the output stage of the compute pipeline.
- Tokens arrive tagged and are parked in a free entry.
- Each token is later retrieved by tag through a CAM lookup, then released.
- Successor to the single-port tag CAM: it adds
  - automatic free-entry allocation,
  - a registered valid/ready output,
  - miss and overflow reporting,
  - an occupancy count and full/empty flags.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- WIDTH_TAG, 4, tag width in bits.
- TYPE_FTK, FTk_t, token type stored per entry.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- I_We  in  1  write request
- I_WTag  in  WIDTH_TAG  tag of the token being written
- I_FTk  in  TYPE_FTK  token to store
- O_Full  out  1  all entries valid
- O_Empty  out  1  no entry valid
- O_Num  out  $clog2(DEPTH)+1  number of valid entries
- O_Ovf  out  1  sticky flag: a write was dropped while full
- I_Seek  in  1  lookup request
- I_STag  in  WIDTH_TAG  tag to look up
- O_SeekRdy  out  1  lookup can be accepted this cycle
- O_Hit  out  1  one-cycle pulse: accepted lookup matched
- O_Miss  out  1  one-cycle pulse: accepted lookup did not match
- O_FTk  out  TYPE_FTK  retrieved token
- O_Valid  out  1  O_FTk is valid
- I_Rdy  in  1  consumer accepts O_FTk

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits cleared; O_Valid=0, O_FTk='0, O_Hit=0, O_Miss=0, O_Ovf=0;
  - O_Num=0, O_Empty=1, O_Full=0, O_SeekRdy=1.
  - Reset mid-operation discards all stored and in-flight tokens; nothing is replayed.
- Entry state: per-entry valid bit, tag register, token register.
- Write:
  - When I_We=1 and not full, the lowest-index free entry (free mask sampled at cycle start) captures I_WTag and I_FTk and becomes valid at the next edge.
  - When I_We=1 and O_Full=1, the write is dropped and O_Ovf is set until reset.
- Seek acceptance: O_SeekRdy = !O_Valid || I_Rdy. A lookup is accepted when I_Seek && O_SeekRdy.
- Accepted lookup, match:
  - I_STag is compared with the tags of all valid entries.
  - On one or more matches, the lowest matching index wins.
  - Its token is loaded into the output register and its valid bit is cleared at the same edge.
  - O_Valid=1 and O_Hit=1 in the next cycle (latency 1).
- Accepted lookup, no match: O_Miss=1 in the next cycle; O_Valid goes to 0 if it was being consumed.
- Non-accepted lookup: ignored, no pulse. The requester must hold the request.
- Output handshake:
  - O_Valid && I_Rdy consumes the token.
  - If there is no simultaneous accepted hit, O_Valid falls to 0.
  - O_FTk holds while O_Valid=1 and I_Rdy=0.
- Simultaneous write and hit: both proceed. The entry freed by the hit is not reusable until the following cycle.
- Simultaneous write and hit at full: the write is dropped (O_Ovf set) because allocation uses the cycle-start free mask.
- Same-cycle write and lookup of the same tag: the lookup misses; the written entry is not yet visible (without the optional feature).
- Duplicate tags are legal; retrieval order is lowest index first.
- Derived status:
  - O_Num = popcount(valid), registered;
  - O_Full = (O_Num==DEPTH);
  - O_Empty = (O_Num==0).
- O_Num bookkeeping: +1 on an accepted write, -1 on an accepted hit, unchanged when both occur.

Optional Feature:
- Macro: TAG_REORDER_BYPASS_EN.
- Defined: an accepted lookup whose I_STag equals I_WTag of a same-cycle accepted write, with no stored match, forwards I_FTk directly to the output register (O_Hit=1 next cycle). No entry is allocated; the write does not count toward O_Num or O_Ovf.
- Undefined: such a lookup misses and the write is stored normally.

Decomposition:
- Package pkg_en holds:
  - type alias for the tag;
  - entry record struct {valid, tag, token};
  - constant for O_Num width.
- Sub-module tag_match_encoder: priority encoder over a DEPTH-bit match or free mask, producing index plus any-bit flag. It is instantiated twice, once for allocation and once for hit selection.

Test Plan:
- Write tags 3,5,7 with tokens A,B,C, then seek 5 with I_Rdy=1 -> O_Hit and O_Valid one cycle later, O_FTk=B, O_Num 3->2.
- Fill all 8 entries, then write a 9th -> O_Full=1, O_Ovf=1 sticky, O_Num=8, 9th token never returned.
- Hold I_Rdy=0 with O_Valid=1, seek tag 3 -> O_SeekRdy=0, no pulse, O_FTk stable; raise I_Rdy -> lookup accepted, new token next cycle.
- Write tag 2 twice (tokens D then E), seek 2 twice -> D returned then E; O_Num reaches 0 and O_Empty=1.
- Seek tag 9 on a buffer holding 1,4 -> O_Miss pulse one cycle, O_Num unchanged; same-cycle write+seek of tag 6 -> miss without the macro, hit with TAG_REORDER_BYPASS_EN.
- Assert reset while O_Valid=1 and O_Num=5 -> all outputs return to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/tag_reorder_buffer_pkg.sv
// rtl/tag_reorder_buffer_pkg.sv - shared types and widths for the tag reorder buffer
package pkg_en;

    localparam int DEPTH_DEF = 8;
    localparam int TAG_W_DEF = 4;
    localparam int NUM_W     = $clog2(DEPTH_DEF) + 1;

    typedef logic [15:0]          FTk_t;
    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
        FTk_t token;
    } entry_t;

endpackage

// File: rtl/tag_reorder_buffer_match_encoder.sv
// rtl/tag_reorder_buffer_match_encoder.sv - lowest-set-bit priority encoder over an entry mask
module tag_match_encoder #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         mask_i,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     any_o
);

    localparam int IW = $clog2(DEPTH);

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/tag_reorder_buffer.sv
// rtl/tag_reorder_buffer.sv - tag-addressed holding buffer with CAM retrieval; TAG_REORDER_BYPASS_EN adds write-to-lookup forwarding
module tag_reorder_buffer
    import pkg_en::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  WIDTH_TAG = 4,
    parameter type TYPE_FTK  = FTk_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_We,
    input  logic [WIDTH_TAG-1:0]   I_WTag,
    input  TYPE_FTK                I_FTk,
    output logic                   O_Full,
    output logic                   O_Empty,
    output logic [$clog2(DEPTH):0] O_Num,
    output logic                   O_Ovf,
    input  logic                   I_Seek,
    input  logic [WIDTH_TAG-1:0]   I_STag,
    output logic                   O_SeekRdy,
    output logic                   O_Hit,
    output logic                   O_Miss,
    output TYPE_FTK                O_FTk,
    output logic                   O_Valid,
    input  logic                   I_Rdy
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [WIDTH_TAG-1:0] tag_q [DEPTH];
    TYPE_FTK              tok_q [DEPTH];
    logic [NW-1:0]        num_q, num_d;
    TYPE_FTK              ftk_q;
    logic                 vld_q, hit_q, miss_q, ovf_q;

    logic [DEPTH-1:0] match_mask;
    logic [IW-1:0]    alloc_idx, hit_idx;
    logic             alloc_any, hit_any;
    logic             full, seek_acc, hit, bypass, wr_acc, wr_store;

    always_comb begin
        match_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_mask[i] = valid_q[i] && (tag_q[i] == I_STag);
        end
    end

    tag_match_encoder #(.DEPTH(DEPTH)) u_alloc (
        .mask_i (~valid_q),
        .idx_o  (alloc_idx),
        .any_o  (alloc_any)
    );

    tag_match_encoder #(.DEPTH(DEPTH)) u_hit (
        .mask_i (match_mask),
        .idx_o  (hit_idx),
        .any_o  (hit_any)
    );

    assign full     = (num_q == NW'(DEPTH));
    assign seek_acc = I_Seek && (!vld_q || I_Rdy);
    assign hit      = seek_acc && hit_any;
    assign wr_acc   = I_We && !full && alloc_any;

`ifdef TAG_REORDER_BYPASS_EN
    assign bypass = seek_acc && !hit_any && wr_acc && (I_STag == I_WTag);
`else
    assign bypass = 1'b0;
`endif

    assign wr_store = wr_acc && !bypass;

    // Allocation slot is free and the hit slot is valid, so they never collide.
    always_comb begin
        valid_d = valid_q;
        if (hit) begin
            valid_d[hit_idx] = 1'b0;
        end
        if (wr_store) begin
            valid_d[alloc_idx] = 1'b1;
        end
        num_d = num_q;
        if (wr_store && !hit) begin
            num_d = num_q + NW'(1);
        end else if (hit && !wr_store) begin
            num_d = num_q - NW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_store) begin
            tag_q[alloc_idx] <= I_WTag;
            tok_q[alloc_idx] <= I_FTk;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            num_q   <= '0;
            ftk_q   <= '0;
            vld_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            num_q   <= num_d;
            hit_q   <= hit || bypass;
            miss_q  <= seek_acc && !hit_any && !bypass;
            ovf_q   <= ovf_q || (I_We && full);
            if (hit) begin
                ftk_q <= tok_q[hit_idx];
                vld_q <= 1'b1;
            end else if (bypass) begin
                ftk_q <= I_FTk;
                vld_q <= 1'b1;
            end else if (I_Rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign O_Full    = full;
    assign O_Empty   = (num_q == '0);
    assign O_Num     = num_q;
    assign O_Ovf     = ovf_q;
    assign O_SeekRdy = !vld_q || I_Rdy;
    assign O_Hit     = hit_q;
    assign O_Miss    = miss_q;
    assign O_FTk     = ftk_q;
    assign O_Valid   = vld_q;

endmodule

// File: tb/tb_tag_reorder_buffer.sv
// tb/tb_tag_reorder_buffer.sv - self-checking bench for tag_reorder_buffer
module tb_tag_reorder_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_We, I_Seek, I_Rdy;
    logic [3:0]  I_WTag, I_STag;
    logic [15:0] I_FTk;
    logic        O_Full, O_Empty, O_Ovf, O_SeekRdy, O_Hit, O_Miss, O_Valid;
    logic [3:0]  O_Num;
    logic [15:0] O_FTk;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    tag_reorder_buffer #(.DEPTH(8), .WIDTH_TAG(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .I_We      (I_We),
        .I_WTag    (I_WTag),
        .I_FTk     (I_FTk),
        .O_Full    (O_Full),
        .O_Empty   (O_Empty),
        .O_Num     (O_Num),
        .O_Ovf     (O_Ovf),
        .I_Seek    (I_Seek),
        .I_STag    (I_STag),
        .O_SeekRdy (O_SeekRdy),
        .O_Hit     (O_Hit),
        .O_Miss    (O_Miss),
        .O_FTk     (O_FTk),
        .O_Valid   (O_Valid),
        .I_Rdy     (I_Rdy)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wtag;
        logic [15:0] ftk;
        logic        seek;
        logic [3:0]  stag;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_ftk;
        logic        e_hit;
        logic        e_miss;
        logic [3:0]  e_num;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic we, input logic [3:0] wtag, input logic [15:0] ftk,
                                input logic seek, input logic [3:0] stag, input logic rdy,
                                input logic ev, input logic [15:0] ef, input logic eh,
                                input logic em, input logic [3:0] en, input logic eo);
        vec_t v;
        v.we = we; v.wtag = wtag; v.ftk = ftk; v.seek = seek; v.stag = stag; v.rdy = rdy;
        v.e_valid = ev; v.e_ftk = ef; v.e_hit = eh; v.e_miss = em; v.e_num = en; v.e_ovf = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [15:0] ef, input logic eh,
                         input logic em, input logic [3:0] en, input logic eo);
        vectors++;
        if ({O_Valid, O_FTk, O_Hit, O_Miss, O_Num, O_Full, O_Empty, O_Ovf} !==
            {ev, ef, eh, em, en, (en == 4'd8), (en == 4'd0), eo}) begin
            miscompares++;
            $display("FAIL %s: got v=%0b ftk=%h hit=%0b miss=%0b num=%0d full=%0b empty=%0b ovf=%0b; want v=%0b ftk=%h hit=%0b miss=%0b num=%0d full=%0b empty=%0b ovf=%0b",
                     name, O_Valid, O_FTk, O_Hit, O_Miss, O_Num, O_Full, O_Empty, O_Ovf,
                     ev, ef, eh, em, en, (en == 4'd8), (en == 4'd0), eo);
        end
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        vectors++;
        if (O_SeekRdy !== exp) begin
            miscompares++;
            $display("FAIL %s: O_SeekRdy got %0b want %0b", name, O_SeekRdy, exp);
        end
    endtask

    task automatic step(input logic we, input logic [3:0] wtag, input logic [15:0] ftk,
                        input logic seek, input logic [3:0] stag, input logic rdy);
        I_We = we; I_WTag = wtag; I_FTk = ftk; I_Seek = seek; I_STag = stag; I_Rdy = rdy;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        I_We = 0; I_Seek = 0; I_Rdy = 0; I_WTag = 0; I_STag = 0; I_FTk = 0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Reference model: entries as plain arrays, retrieval by first matching index.
    logic        m_v[8];
    logic [3:0]  m_t[8];
    logic [15:0] m_k[8];
    logic        m_ov, m_hit, m_miss, m_ovf;
    logic [15:0] m_ftk;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_v[i]);
        return c;
    endfunction

    initial begin
        reset = 1'b0;
        I_We = 0; I_Seek = 0; I_Rdy = 0; I_WTag = 0; I_STag = 0; I_FTk = 0;
        #1;
        check("reset_state", 0, 16'h0, 0, 0, 4'd0, 0);
        chk_rdy("reset_seekrdy", 1'b1);

        tbl[0]  = mk(1, 3, 16'h00A0, 0, 0, 0,  0, 16'h0000, 0, 0, 1, 0);
        tbl[1]  = mk(1, 5, 16'h00B0, 0, 0, 0,  0, 16'h0000, 0, 0, 2, 0);
        tbl[2]  = mk(1, 7, 16'h00C0, 0, 0, 0,  0, 16'h0000, 0, 0, 3, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 1, 5, 1,  1, 16'h00B0, 1, 0, 2, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 1,  0, 16'h00B0, 0, 0, 2, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 1, 3, 1,  1, 16'h00A0, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 7, 1,  1, 16'h00C0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 0, 1,  0, 16'h00C0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 2, 16'h00D0, 0, 0, 1,  0, 16'h00C0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 2, 16'h00E0, 0, 0, 1,  0, 16'h00C0, 0, 0, 2, 0);
        tbl[10] = mk(0, 0, 16'h0000, 1, 2, 1,  1, 16'h00D0, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 16'h0000, 1, 2, 1,  1, 16'h00E0, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 1,  0, 16'h00E0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 16'h0011, 0, 0, 1,  0, 16'h00E0, 0, 0, 1, 0);
        tbl[14] = mk(1, 4, 16'h0044, 0, 0, 1,  0, 16'h00E0, 0, 0, 2, 0);
        tbl[15] = mk(0, 0, 16'h0000, 1, 9, 1,  0, 16'h00E0, 0, 1, 2, 0);
`ifdef TAG_REORDER_BYPASS_EN
        tbl[16] = mk(1, 6, 16'h0066, 1, 6, 1,  1, 16'h0066, 1, 0, 2, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 0, 1,  0, 16'h0066, 0, 0, 2, 0);
`else
        tbl[16] = mk(1, 6, 16'h0066, 1, 6, 1,  0, 16'h00E0, 0, 1, 3, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 0, 1,  0, 16'h00E0, 0, 0, 3, 0);
`endif

        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].we, tbl[i].wtag, tbl[i].ftk, tbl[i].seek, tbl[i].stag, tbl[i].rdy);
            check($sformatf("table_%0d", i), tbl[i].e_valid, tbl[i].e_ftk, tbl[i].e_hit,
                  tbl[i].e_miss, tbl[i].e_num, tbl[i].e_ovf);
        end

        // Fill, overflow, then drain in order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 4'(i), 16'h0100 + 16'(i), 0, 0, 1);
            check($sformatf("fill_%0d", i), 0, 16'h0, 0, 0, 4'(i + 1), 0);
        end
        step(1, 9, 16'h01FF, 0, 0, 1);
        check("overflow_write", 0, 16'h0, 0, 0, 4'd8, 1);
        step(0, 0, 16'h0, 0, 0, 1);
        check("overflow_sticky", 0, 16'h0, 0, 0, 4'd8, 1);
        step(0, 0, 16'h0, 1, 9, 1);
        check("dropped_tag_miss", 0, 16'h0, 0, 1, 4'd8, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 16'h0, 1, 4'(i), 1);
            check($sformatf("drain_%0d", i), 1, 16'h0100 + 16'(i), 1, 0, 4'(7 - i), 1);
        end
        step(0, 0, 16'h0, 0, 0, 1);
        check("drain_idle", 0, 16'h0107, 0, 0, 4'd0, 1);

        // Backpressure holds the output and blocks lookups.
        do_reset();
        step(1, 3, 16'h0033, 0, 0, 1);
        step(1, 8, 16'h0088, 0, 0, 1);
        check("bp_loaded", 0, 16'h0, 0, 0, 4'd2, 0);
        step(0, 0, 16'h0, 1, 8, 1);
        check("bp_first_hit", 1, 16'h0088, 1, 0, 4'd1, 0);
        I_Seek = 1; I_STag = 3; I_Rdy = 0;
        #1;
        chk_rdy("bp_seekrdy_low", 1'b0);
        step(0, 0, 16'h0, 1, 3, 0);
        check("bp_held", 1, 16'h0088, 0, 0, 4'd1, 0);
        step(0, 0, 16'h0, 1, 3, 0);
        check("bp_held2", 1, 16'h0088, 0, 0, 4'd1, 0);
        I_Rdy = 1;
        #1;
        chk_rdy("bp_seekrdy_high", 1'b1);
        step(0, 0, 16'h0, 1, 3, 1);
        check("bp_released", 1, 16'h0033, 1, 0, 4'd0, 0);
        step(0, 0, 16'h0, 0, 0, 1);
        check("bp_consumed", 0, 16'h0033, 0, 0, 4'd0, 0);

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 4'(10 + i), 16'h0200 + 16'(i), 0, 0, 1);
        step(0, 0, 16'h0, 1, 10, 1);
        check("pre_async_reset", 1, 16'h0200, 1, 0, 4'd5, 0);
        I_Rdy = 0; I_Seek = 0;
        #2 reset = 1'b0;
        #1;
        check("async_reset", 0, 16'h0, 0, 0, 4'd0, 0);
        chk_rdy("async_reset_seekrdy", 1'b1);
        @(negedge clock);
        reset = 1'b1;
        step(0, 0, 16'h0, 1, 11, 1);
        check("after_reset_no_replay", 0, 16'h0, 0, 1, 4'd0, 0);

        // Randomised run against the reference model.
        do_reset();
        for (int i = 0; i < 8; i++) m_v[i] = 0;
        m_ov = 0; m_hit = 0; m_miss = 0; m_ovf = 0; m_ftk = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        we, seek, rdy, acc, full, wacc, byp;
            logic [3:0]  wtag, stag;
            logic [15:0] ftk;
            int          hi, fi;
            we   = ($urandom_range(0, 99) < 55);
            seek = ($urandom_range(0, 99) < 50);
            rdy  = ($urandom_range(0, 99) < 70);
            wtag = 4'($urandom_range(0, 3));
            stag = 4'($urandom_range(0, 3));
            ftk  = 16'($urandom);
            I_We = we; I_WTag = wtag; I_FTk = ftk; I_Seek = seek; I_STag = stag; I_Rdy = rdy;
            #1;
            chk_rdy($sformatf("rand_seekrdy_%0d", c), !m_ov || rdy);

            acc  = seek && (!m_ov || rdy);
            full = (m_count() == 8);
            wacc = we && !full;
            hi = -1;
            fi = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m_v[i] && m_t[i] == stag) hi = i;
                if (!m_v[i]) fi = i;
            end
            byp = 0;
`ifdef TAG_REORDER_BYPASS_EN
            byp = acc && (hi < 0) && wacc && (stag == wtag);
`endif
            m_hit  = acc && ((hi >= 0) || byp);
            m_miss = acc && (hi < 0) && !byp;
            if (acc && hi >= 0) begin
                m_ftk = m_k[hi]; m_ov = 1; m_v[hi] = 0;
            end else if (byp) begin
                m_ftk = ftk; m_ov = 1;
            end else if (rdy) begin
                m_ov = 0;
            end
            if (wacc && !byp) begin
                m_v[fi] = 1; m_t[fi] = wtag; m_k[fi] = ftk;
            end
            if (we && full) m_ovf = 1;

            @(posedge clock);
            @(negedge clock);
            check($sformatf("rand_%0d", c), m_ov, m_ftk, m_hit, m_miss, 4'(m_count()), m_ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
